// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage MIPS core: D-stage stall and forwarding selects from shadow E/M/W writer records.
// Build option HAZARD_FWD_EN enables forwarding with Tuse/Tnew stalling; without it the unit is a plain interlock.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_D,
  output logic             stall,
  output logic [1:0]       fwd_rs_D,
  output logic [1:0]       fwd_rt_D,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic             fwd_rt_M,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [1:0] TUSE_NONE  = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } rec_t;

  // W sources are never inspected, only its destination and age
  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } wrec_t;

  rec_t             dec_d, e_q, e_d, m_q, m_d;
  wrec_t            w_q, w_d;
  logic [1:0]       tuse_rs, tuse_rt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_bits;

  function automatic logic writes(input logic [4:0] a3, input logic [4:0] r);
    return (a3 == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_comb begin : decode
    dec_d   = '{rs: instr_D[25:21], rt: instr_D[20:16], a3: 5'd0, tnew: 2'd0};
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    case (instr_D[31:26])
      OP_SPECIAL: begin
        case (instr_D[5:0])
          FN_ADDU, FN_SUBU: begin
            tuse_rs    = 2'd1;
            tuse_rt    = 2'd1;
            dec_d.a3   = instr_D[15:11];
            dec_d.tnew = 2'd1;
          end
          FN_JALR: begin
            tuse_rs    = 2'd0;
            dec_d.a3   = instr_D[15:11];
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        tuse_rs    = 2'd1;
        dec_d.a3   = instr_D[20:16];
        dec_d.tnew = 2'd1;
      end
      OP_LUI: begin
        dec_d.a3   = instr_D[20:16];
        dec_d.tnew = 2'd1;
      end
      OP_LW: begin
        tuse_rs    = 2'd1;
        dec_d.a3   = instr_D[20:16];
        dec_d.tnew = 2'd2;
      end
      OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_JAL:  dec_d.a3 = 5'd31;
      default: ;
    endcase
  end

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] sel_d(input rec_t e, input rec_t m, input wrec_t w,
                                       input logic [4:0] r);
    if (writes(e.a3, r) && e.tnew == 2'd0)      return 2'b11;
    else if (writes(m.a3, r) && m.tnew == 2'd0) return 2'b01;
    else if (writes(w.a3, r) && w.tnew == 2'd0) return 2'b10;
    else                                        return 2'b00;
  endfunction

  function automatic logic [1:0] sel_e(input rec_t m, input wrec_t w, input logic [4:0] r);
    if (writes(m.a3, r) && m.tnew == 2'd0)      return 2'b01;
    else if (writes(w.a3, r) && w.tnew == 2'd0) return 2'b10;
    else                                        return 2'b00;
  endfunction
`endif

  always_comb begin : hazard
    stall    = 1'b0;
    fwd_rs_D = 2'b00;
    fwd_rt_D = 2'b00;
    fwd_rs_E = 2'b00;
    fwd_rt_E = 2'b00;
    fwd_rt_M = 1'b0;
`ifdef HAZARD_FWD_EN
    // W never stalls: a value there is already forwardable or written through
    stall = ((tuse_rs != TUSE_NONE) &&
             ((writes(e_q.a3, dec_d.rs) && e_q.tnew > tuse_rs) ||
              (writes(m_q.a3, dec_d.rs) && m_q.tnew > tuse_rs))) ||
            ((tuse_rt != TUSE_NONE) &&
             ((writes(e_q.a3, dec_d.rt) && e_q.tnew > tuse_rt) ||
              (writes(m_q.a3, dec_d.rt) && m_q.tnew > tuse_rt)));
    fwd_rs_D = sel_d(e_q, m_q, w_q, dec_d.rs);
    fwd_rt_D = sel_d(e_q, m_q, w_q, dec_d.rt);
    fwd_rs_E = sel_e(m_q, w_q, e_q.rs);
    fwd_rt_E = sel_e(m_q, w_q, e_q.rt);
    fwd_rt_M = writes(w_q.a3, m_q.rt);
`else
    stall = ((tuse_rs != TUSE_NONE) &&
             (writes(e_q.a3, dec_d.rs) || writes(m_q.a3, dec_d.rs) ||
              writes(w_q.a3, dec_d.rs))) ||
            ((tuse_rt != TUSE_NONE) &&
             (writes(e_q.a3, dec_d.rt) || writes(m_q.a3, dec_d.rt) ||
              writes(w_q.a3, dec_d.rt)));
`endif
  end

  always_comb begin : next_state
    e_d   = stall ? '0 : dec_d;
    m_d   = '{rs: e_q.rs, rt: e_q.rt, a3: e_q.a3, tnew: tnew_dec(e_q.tnew)};
    w_d   = '{a3: m_q.a3, tnew: tnew_dec(m_q.tnew)};
    cnt_d = (stall && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt   = cnt_q;
  assign unused_bits = ^{instr_D[10:6], e_q, m_q, w_q};

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random instruction streams
// compared against an instruction-age pipeline model.
module tb_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int OP_JAL  = 3;
  localparam int OP_BEQ  = 4;
  localparam int OP_ORI  = 13;
  localparam int OP_LUI  = 15;
  localparam int OP_LW   = 35;
  localparam int OP_SW   = 43;
  localparam int OP_J    = 2;
  localparam int FN_JALR = 9;
  localparam int FN_ADDU = 33;
  localparam int FN_SUBU = 35;

  logic             clk;
  logic             rst_n;
  logic [31:0]      instr_D;
  logic             stall;
  logic [1:0]       fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic             fwd_rt_M;
  logic [CNT_W-1:0] stall_cnt;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .stall(stall),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
    .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rs, rt, tu_rs, tu_rt, a3, tnew;
  } mdec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] pipe [3];   // instruction words in E, M, W (0 = bubble)
  int          mcnt;
  int          e_stall, e_fm;
  int          e_fd [2];
  int          e_fe [2];
  logic [1:0]  s_frsD, s_frtD, s_frsE, s_frtE;
  logic        s_fm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = '0;
    w[25:21] = rs[4:0]; w[20:16] = rt[4:0]; w[15:11] = rd[4:0]; w[5:0] = fn[5:0];
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w[31:26] = op[5:0]; w[25:21] = rs[4:0]; w[20:16] = rt[4:0]; w[15:0] = imm[15:0];
    return w;
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    logic [31:0] w;
    w[31:26] = op[5:0]; w[25:0] = tgt[25:0];
    return w;
  endfunction

  function automatic int rreg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 31 : r;
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, a, b, c, imm;
    k = int'($urandom_range(0, 10));
    a = rreg(); b = rreg(); c = rreg(); imm = int'($urandom);
    case (k)
      0:       return enc_r(a, b, c, FN_ADDU);
      1:       return enc_r(a, b, c, FN_SUBU);
      2:       return enc_i(OP_ORI, a, b, imm);
      3:       return enc_i(OP_LUI, 0, b, imm);
      4:       return enc_i(OP_LW, a, b, imm);
      5:       return enc_i(OP_SW, a, b, imm);
      6:       return enc_i(OP_BEQ, a, b, imm);
      7:       return enc_j(OP_J, imm);
      8:       return enc_j(OP_JAL, imm);
      9:       return enc_r(a, 0, c, FN_JALR);
      default: return $urandom;
    endcase
  endfunction

  // Reference decode: what each instruction reads, when, and what it produces.
  function automatic mdec_t mdecode(input logic [31:0] w);
    mdec_t d;
    int op, fn;
    op = int'(w[31:26]); fn = int'(w[5:0]);
    d.rs = int'(w[25:21]); d.rt = int'(w[20:16]);
    d.tu_rs = 3; d.tu_rt = 3; d.a3 = 0; d.tnew = 0;
    if (op == 0 && (fn == FN_ADDU || fn == FN_SUBU)) begin
      d.tu_rs = 1; d.tu_rt = 1; d.a3 = int'(w[15:11]); d.tnew = 1;
    end else if (op == 0 && fn == FN_JALR) begin
      d.tu_rs = 0; d.a3 = int'(w[15:11]);
    end else if (op == OP_ORI) begin
      d.tu_rs = 1; d.a3 = d.rt; d.tnew = 1;
    end else if (op == OP_LUI) begin
      d.a3 = d.rt; d.tnew = 1;
    end else if (op == OP_LW) begin
      d.tu_rs = 1; d.a3 = d.rt; d.tnew = 2;
    end else if (op == OP_SW) begin
      d.tu_rs = 1; d.tu_rt = 2;
    end else if (op == OP_BEQ) begin
      d.tu_rs = 0; d.tu_rt = 0;
    end else if (op == OP_JAL) begin
      d.a3 = 31;
    end
    return d;
  endfunction

  function automatic bit mwr(input int a3, input int r);
    return (a3 == r) && (r != 0);
  endfunction

  task automatic model_eval(input logic [31:0] ins);
    mdec_t dd;
    mdec_t st [3];
    int    tn [3];
    int    src [2];
    int    tu [2];
    int    code [3];
    code = '{3, 1, 2};
    dd = mdecode(ins);
    src = '{dd.rs, dd.rt};
    tu  = '{dd.tu_rs, dd.tu_rt};
    for (int k = 0; k < 3; k++) begin
      st[k] = mdecode(pipe[k]);
      tn[k] = (st[k].tnew - k > 0) ? st[k].tnew - k : 0;
    end
    e_stall = 0; e_fm = 0;
    e_fd = '{0, 0}; e_fe = '{0, 0};
`ifdef HAZARD_FWD_EN
    for (int s = 0; s < 2; s++) begin
      if (tu[s] < 3)
        for (int k = 0; k < 2; k++)
          if (mwr(st[k].a3, src[s]) && tn[k] > tu[s]) e_stall = 1;
      for (int k = 2; k >= 0; k--)
        if (mwr(st[k].a3, src[s]) && tn[k] == 0) e_fd[s] = code[k];
      for (int k = 2; k >= 1; k--)
        if (mwr(st[k].a3, (s == 0) ? st[0].rs : st[0].rt) && tn[k] == 0) e_fe[s] = code[k];
    end
    e_fm = mwr(st[2].a3, st[1].rt) ? 1 : 0;
`else
    for (int s = 0; s < 2; s++)
      if (tu[s] < 3)
        for (int k = 0; k < 3; k++)
          if (mwr(st[k].a3, src[s])) e_stall = 1;
`endif
  endtask

  task automatic model_reset();
    pipe = '{32'h0, 32'h0, 32'h0};
    mcnt = 0;
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances the model.
  task automatic step(input logic [31:0] ins, output logic st);
    instr_D = ins;
    @(negedge clk);
    model_eval(ins);
    s_frsD = fwd_rs_D; s_frtD = fwd_rt_D; s_frsE = fwd_rs_E; s_frtE = fwd_rt_E; s_fm = fwd_rt_M;
    chk("stall", stall, e_stall);
    chk("fwd_rs_D", fwd_rs_D, e_fd[0]);
    chk("fwd_rt_D", fwd_rt_D, e_fd[1]);
    chk("fwd_rs_E", fwd_rs_E, e_fe[0]);
    chk("fwd_rt_E", fwd_rt_E, e_fe[1]);
    chk("fwd_rt_M", fwd_rt_M, e_fm);
    chk("stall_cnt", stall_cnt, mcnt);
    st = stall;
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (e_stall != 0) ? 32'h0 : ins;
    if (e_stall != 0 && mcnt < CNT_MAX) mcnt++;
    #1;
  endtask

  // Holds the instruction in D until the DUT releases the stall; returns stalled cycles.
  task automatic issue(input logic [31:0] ins, output int nst);
    logic st;
    bit   done;
    nst = 0; done = 0;
    for (int i = 0; i < 6 && !done; i++) begin
      step(ins, st);
      if (st === 1'b1) nst++;
      else done = 1;
    end
    chk("issue_bound", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int nst;
    rst_n   = 1'b0;
    instr_D = enc_r(1, 2, 3, FN_ADDU);
    model_reset();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef HAZARD_FWD_EN
    issue(enc_i(OP_LW, 0, 1, 0), nst);
    issue(enc_r(1, 1, 2, FN_ADDU), nst);
    chk("lw_addu_nstall", nst, 1);
    chk("lw_addu_cnt", stall_cnt, 1);
    instr_D = 32'h0;
    #1;
    chk("addu_in_E_fwd_rs", fwd_rs_E, 2'b10);
    chk("addu_in_E_fwd_rt", fwd_rt_E, 2'b10);
    issue(enc_r(1, 2, 3, FN_ADDU), nst);
    issue(enc_i(OP_BEQ, 3, 0, 4), nst);
    chk("addu_beq_nstall", nst, 1);
    chk("beq_fwd_rs_D", s_frsD, 2'b01);
    chk("beq_fwd_rt_D", s_frtD, 2'b00);
    issue(enc_i(OP_LW, 0, 4, 0), nst);
    issue(enc_i(OP_SW, 5, 4, 0), nst);
    chk("lw_sw_nstall", nst, 0);
    issue(32'h0, nst);
    instr_D = 32'h0;
    #1;
    chk("sw_in_M_fwd_rt_M", fwd_rt_M, 1);
    issue(enc_j(OP_JAL, 'h40), nst);
    issue(enc_r(31, 0, 2, FN_JALR), nst);
    chk("jal_jalr_nstall", nst, 0);
    chk("jalr_fwd_rs_D", s_frsD, 2'b11);
`else
    issue(enc_r(1, 2, 3, FN_ADDU), nst);
    issue(enc_i(OP_ORI, 3, 4, 1), nst);
    chk("addu_ori_nstall", nst, 3);
    chk("addu_ori_cnt", stall_cnt, 3);
    chk("nofwd_rs_D", s_frsD, 2'b00);
    chk("nofwd_rs_E", s_frsE, 2'b00);
    chk("nofwd_rt_E", s_frtE, 2'b00);
    chk("nofwd_rt_M", s_fm, 1'b0);
    issue(enc_i(OP_LW, 0, 1, 0), nst);
    issue(enc_r(1, 1, 2, FN_ADDU), nst);
    chk("lw_addu_nstall", nst, 3);
`endif
    issue(enc_i(OP_ORI, 0, 0, 5), nst);
    issue(enc_r(0, 0, 6, FN_ADDU), nst);
    chk("r0_nstall", nst, 0);
    chk("r0_fwd_rs_D", s_frsD, 2'b00);
    chk("r0_fwd_rt_D", s_frtD, 2'b00);

    // Reset in the middle of a stall
    issue(enc_i(OP_LW, 0, 7, 0), nst);
    instr_D = enc_r(7, 7, 8, FN_ADDU);
    @(negedge clk);
    chk("pre_rst_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_fwd_rs_D", fwd_rs_D, 0);
    chk("midrst_fwd_rt_M", fwd_rt_M, 0);
    chk("midrst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_stall", stall, 0);
    chk("rst_hold_fwd_rs_E", fwd_rs_E, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 300; n++) issue(rand_instr(), nst);

    for (int n = 0; n < 16; n++) begin
      issue(enc_i(OP_LW, 0, 1, 0), nst);
      issue(enc_r(1, 1, 2, FN_ADDU), nst);
    end
    chk("cnt_saturated", stall_cnt, CNT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
